// File: rtl/fir_sym_param.sv
// Symmetric linear-phase FIR with pre-add, registered adder tree,
// run-time coefficients, round-half-up, saturation and bypass.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   IN_VALID          NOISE_SIGNAL qualifier; delay line shifts only when set
//   NOISE_SIGNAL      signed input sample (DATA_W)
//   BYPASS            1: output the centre-tap sample instead of the filter sum
//   COEF_WE/ADDR/DATA unique-coefficient write port (ADDR >= U ignored)
//   OUT_VALID         FILTERED_SIGNAL/OUT_SAT valid this cycle
//   FILTERED_SIGNAL   signed output (OUT_W)
//   OUT_SAT           output was clamped
module fir_sym_param #(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int TAPS      = 9,
   parameter int OUT_W     = 16,
   parameter int OUT_SHIFT = 14
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     IN_VALID,
   input  logic signed [DATA_W-1:0] NOISE_SIGNAL,
   input  logic                     BYPASS,
   input  logic                     COEF_WE,
   input  logic [4:0]               COEF_ADDR,
   input  logic signed [COEF_W-1:0] COEF_DATA,
   output logic                     OUT_VALID,
   output logic signed [OUT_W-1:0]  FILTERED_SIGNAL,
   output logic                     OUT_SAT
);

   localparam int U  = (TAPS + 1) / 2;
   localparam int A  = $clog2(U);
   localparam int PW = DATA_W + 1;
   localparam int MW = DATA_W + COEF_W + 1;
   localparam int SW = MW + A;

   localparam logic signed [COEF_W-1:0] C_ID = COEF_W'(1) << OUT_SHIFT;
   localparam logic signed [SW-1:0] HALF = SW'(1) <<< (OUT_SHIFT - 1);
   localparam logic signed [SW-1:0] OMAX =
      {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SW-1:0] OMIN =
      {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // operand count feeding tree level l+1
   function automatic int lvl_cnt(input int l);
      int n;
      n = U;
      for (int k = 0; k < l; k++) n = (n + 1) / 2;
      return n;
   endfunction

   logic signed [DATA_W-1:0] x     [TAPS];
   logic signed [COEF_W-1:0] coef  [U];
   logic signed [PW-1:0]     p     [U];
   // level 0 holds products; rows padded to 2U so pair indices stay in range
   logic signed [SW-1:0]     tr    [A+1][2*U];
   logic                     vin;
   logic                     vp    [A+2];
   logic                     bp_en [A+2];
   logic signed [DATA_W-1:0] bp_d  [A+2];

   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] rnd;
   logic signed [SW-1:0] val;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < TAPS; i++) x[i] <= '0;
      end else if (IN_VALID) begin
         x[0] <= NOISE_SIGNAL;
         for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < U; i++)
            coef[i] <= (i == U - 1) ? C_ID : '0;
      end else if (COEF_WE) begin
         for (int i = 0; i < U; i++)
            if (COEF_ADDR == 5'(i)) coef[i] <= COEF_DATA;
      end
   end

   // pre-add, multiply and the side pipes for valid/bypass
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < U; i++) p[i] <= '0;
         for (int j = 0; j < 2 * U; j++) tr[0][j] <= '0;
         vin <= 1'b0;
         for (int k = 0; k < A + 2; k++) begin
            vp[k]    <= 1'b0;
            bp_en[k] <= 1'b0;
            bp_d[k]  <= '0;
         end
      end else begin
         for (int i = 0; i < U - 1; i++)
            p[i] <= PW'(x[i]) + PW'(x[TAPS-1-i]);
         p[U-1] <= PW'(x[U-1]);
         for (int j = 0; j < U; j++)
            tr[0][j] <= SW'(p[j]) * SW'(coef[j]);
         for (int j = U; j < 2 * U; j++) tr[0][j] <= '0;
         vin      <= IN_VALID;
         vp[0]    <= vin;
         bp_en[0] <= BYPASS;
         bp_d[0]  <= x[U-1];
         for (int k = 1; k < A + 2; k++) begin
            vp[k]    <= vp[k-1];
            bp_en[k] <= bp_en[k-1];
            bp_d[k]  <= bp_d[k-1];
         end
      end
   end

   // adder tree: pairs summed, an odd leftover is registered through
   always_ff @(posedge CLK) begin
      for (int l = 1; l <= A; l++) begin
         for (int j = 0; j < U; j++) begin
            if (RST)
               tr[l][j] <= '0;
            else if (2 * j + 1 < lvl_cnt(l - 1))
               tr[l][j] <= tr[l-1][2*j] + tr[l-1][2*j+1];
            else if (2 * j < lvl_cnt(l - 1))
               tr[l][j] <= tr[l-1][2*j];
            else
               tr[l][j] <= '0;
         end
         for (int j = U; j < 2 * U; j++) tr[l][j] <= '0;
      end
   end

   always_comb begin
      sum = tr[A][0];
      rnd = (sum + HALF) >>> OUT_SHIFT;
      val = bp_en[A+1] ? SW'(bp_d[A+1]) : rnd;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_VALID       <= 1'b0;
         FILTERED_SIGNAL <= '0;
         OUT_SAT         <= 1'b0;
      end else begin
         OUT_VALID <= vp[A+1];
         if (vp[A+1]) begin
            if (val > OMAX) begin
               FILTERED_SIGNAL <= OMAX[OUT_W-1:0];
               OUT_SAT         <= 1'b1;
            end else if (val < OMIN) begin
               FILTERED_SIGNAL <= OMIN[OUT_W-1:0];
               OUT_SAT         <= 1'b1;
            end else begin
               FILTERED_SIGNAL <= val[OUT_W-1:0];
               OUT_SAT         <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_sym_param.sv
// Self-checking bench for fir_sym_param: vector table, directed
// sequences and randomized stream against a convolution model.
module tb_fir_sym_param;

   localparam int T   = 9;
   localparam int U   = 5;
   localparam int SH  = 14;
   localparam int LAT = 6;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IN_VALID = 1'b0;
   logic [15:0] NOISE_SIGNAL = '0;
   logic        BYPASS = 1'b0;
   logic        COEF_WE = 1'b0;
   logic [4:0]  COEF_ADDR = '0;
   logic [15:0] COEF_DATA = '0;
   logic        OUT_VALID;
   logic [15:0] FILTERED_SIGNAL;
   logic        OUT_SAT;

   always #5 CLK = ~CLK;

   fir_sym_param dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID),
      .NOISE_SIGNAL(NOISE_SIGNAL), .BYPASS(BYPASS),
      .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA),
      .OUT_VALID(OUT_VALID), .FILTERED_SIGNAL(FILTERED_SIGNAL),
      .OUT_SAT(OUT_SAT)
   );

   typedef struct {
      logic [15:0] y;
      logic        sat;
      int          due;
   } exp_t;

   typedef struct {
      logic [15:0] cc;
      bit          all;
      bit          byp;
      logic [15:0] din;
      logic [15:0] ey;
      bit          es;
   } vec_t;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   longint m_coef [U];
   longint hist   [T];
   exp_t   q [$];
   logic [15:0] outs [$];
   int          ocyc [$];
   logic [15:0] last_y;
   logic        last_sat;

   logic [15:0] t2c [U] = '{16'h04F6, 16'h0A34, 16'h1089, 16'h1496, 16'h160F};
   vec_t tbl [8];

   function automatic void m_reset();
      for (int i = 0; i < T; i++) hist[i] = 0;
      for (int i = 0; i < U; i++) m_coef[i] = (i == U - 1) ? (64'sd1 <<< SH) : 0;
      q.delete();
   endfunction

   function automatic exp_t m_out(input bit byp, input int due);
      exp_t e;
      longint acc, r, h;
      acc = 0;
      for (int k = 0; k < T; k++) begin
         h = (k < U) ? m_coef[k] : m_coef[T-1-k];
         acc += h * hist[k];
      end
      r = (acc + (64'sd1 <<< (SH - 1))) >>> SH;
      if (byp) r = hist[U-1];
      if (r > 32767) begin
         e.y = 16'h7FFF; e.sat = 1'b1;
      end else if (r < -32768) begin
         e.y = 16'h8000; e.sat = 1'b1;
      end else begin
         e.y = r[15:0]; e.sat = 1'b0;
      end
      e.due = due;
      return e;
   endfunction

   task automatic chk(input string name, input longint got, input longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      logic r, iv, b, we;
      logic [15:0] d, cd;
      logic [4:0] ad;
      exp_t e;
      r = RST; iv = IN_VALID; d = NOISE_SIGNAL; b = BYPASS;
      we = COEF_WE; ad = COEF_ADDR; cd = COEF_DATA;
      @(posedge CLK);
      #1;
      cyc++;
      if (r) begin
         m_reset();
      end else begin
         if (we && ad < 5'(U)) m_coef[ad] = longint'($signed(cd));
         if (iv) begin
            for (int k = T - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = longint'($signed(d));
            q.push_back(m_out(b, cyc + LAT));
         end
      end
      if (OUT_VALID) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL out_unexpected cyc=%0d got=%h", cyc, FILTERED_SIGNAL);
         end else begin
            e = q.pop_front();
            if (FILTERED_SIGNAL !== e.y || OUT_SAT !== e.sat || cyc != e.due) begin
               fails++;
               $display("FAIL out_check cyc=%0d got=%h/%0b exp=%h/%0b due=%0d",
                        cyc, FILTERED_SIGNAL, OUT_SAT, e.y, e.sat, e.due);
            end
         end
         last_y   = FILTERED_SIGNAL;
         last_sat = OUT_SAT;
         outs.push_back(FILTERED_SIGNAL);
         ocyc.push_back(cyc);
      end
   endtask

   task automatic put(input logic iv, input logic [15:0] d);
      IN_VALID = iv;
      NOISE_SIGNAL = d;
      tick();
   endtask

   task automatic wcoef(input logic [4:0] a, input logic [15:0] d);
      COEF_WE = 1'b1; COEF_ADDR = a; COEF_DATA = d;
      tick();
      COEF_WE = 1'b0;
   endtask

   task automatic do_reset();
      IN_VALID = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      IN_VALID = 1'b0;
      while (q.size() > 0 && n < 40) begin
         tick();
         n++;
      end
      chk("drain_pending", q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ac;
      tbl[0] = '{16'h2000, 0, 0, 16'h0003, 16'h0002, 0};
      tbl[1] = '{16'h2000, 0, 0, 16'hFFFD, 16'hFFFF, 0};
      tbl[2] = '{16'h2000, 0, 0, 16'h0001, 16'h0001, 0};
      tbl[3] = '{16'h2000, 0, 0, 16'hFFFF, 16'h0000, 0};
      tbl[4] = '{16'h7FFF, 1, 0, 16'h7FFF, 16'h7FFF, 1};
      tbl[5] = '{16'h7FFF, 1, 0, 16'h8000, 16'h8000, 1};
      tbl[6] = '{16'h4000, 0, 1, 16'h8000, 16'h8000, 0};
      tbl[7] = '{16'h4000, 0, 0, 16'h1234, 16'h1234, 0};
      m_reset();

      // impulse through identity coefficients
      do_reset();
      chk("rst_valid", OUT_VALID, 0);
      chk("rst_data", FILTERED_SIGNAL, 0);
      chk("rst_sat", OUT_SAT, 0);
      outs.delete(); ocyc.delete();
      put(1, 16'h1000);
      ac = cyc;
      for (int i = 0; i < 8; i++) put(1, 16'h0000);
      drain();
      chk("t1_count", outs.size(), 9);
      chk("t1_idx3", outs[3], 16'h0000);
      chk("t1_idx4", outs[4], 16'h1000);
      chk("t1_latency", ocyc[0] - ac, LAT);

      // impulse through written coefficients
      do_reset();
      for (int a = 0; a < U; a++) wcoef(5'(a), t2c[a]);
      outs.delete(); ocyc.delete();
      put(1, 16'h4000);
      for (int i = 0; i < 12; i++) put(1, 16'h0000);
      drain();
      for (int i = 0; i < 13; i++)
         chk($sformatf("t2_out%0d", i), outs[i],
             (i < 9) ? t2c[(i < U) ? i : T - 1 - i] : 16'h0000);

      // rounding / saturation / bypass table
      foreach (tbl[v]) begin
         do_reset();
         for (int a = 0; a < U; a++)
            wcoef(5'(a), (tbl[v].all || a == U - 1) ? tbl[v].cc : 16'h0000);
         BYPASS = tbl[v].byp;
         for (int i = 0; i < T; i++) put(1, tbl[v].din);
         drain();
         BYPASS = 1'b0;
         chk($sformatf("tbl%0d_y", v), last_y, tbl[v].ey);
         chk($sformatf("tbl%0d_sat", v), last_sat, tbl[v].es);
      end

      // gapped input
      do_reset();
      for (int a = 0; a < U; a++) wcoef(5'(a), t2c[a]);
      outs.delete(); ocyc.delete();
      for (int k = 0; k < 10; k++) begin
         put(1, (k == 0) ? 16'h4000 : 16'h0000);
         put(0, 16'hDEAD);
      end
      drain();
      chk("t5_count", outs.size(), 10);
      for (int i = 0; i < 9; i++)
         chk($sformatf("t5_out%0d", i), outs[i], t2c[(i < U) ? i : T - 1 - i]);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t5_gap%0d", i), ocyc[i+1] - ocyc[i], 2);

      // reset mid-stream with bypass and a colliding coefficient write
      do_reset();
      BYPASS = 1'b1;
      for (int i = 0; i < 10; i++) put(1, 16'($urandom));
      IN_VALID = 1'b1; NOISE_SIGNAL = 16'h5555;
      COEF_WE = 1'b1; COEF_ADDR = 5'd4; COEF_DATA = 16'h1000;
      RST = 1'b1;
      tick();
      RST = 1'b0; COEF_WE = 1'b0;
      chk("t6_valid", OUT_VALID, 0);
      chk("t6_data", FILTERED_SIGNAL, 0);
      outs.delete(); ocyc.delete();
      put(1, 16'h1234);
      for (int i = 0; i < 4; i++) put(1, 16'h0000);
      ac = cyc;
      drain();
      BYPASS = 1'b0;
      chk("t6_byp_y", last_y, 16'h1234);
      chk("t6_byp_lat", ocyc[ocyc.size()-1] - ac, LAT);
      put(1, 16'h0777);
      for (int i = 0; i < 4; i++) put(1, 16'h0000);
      drain();
      chk("t6_identity", last_y, 16'h0777);

      // randomized segments against the model
      for (int s = 0; s < 6; s++) begin
         for (int a = 0; a < U; a++)
            wcoef(5'(a), 16'($signed(16'($urandom_range(0, 16'h3FFF))) - 16'sh2000));
         wcoef(5'($urandom_range(U, 31)), 16'($urandom));
         BYPASS = s[0];
         for (int i = 0; i < 60; i++)
            put(1'($urandom_range(0, 1)), 16'($urandom));
         drain();
         BYPASS = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fir_sym_param.md
Name: fir_sym_param

Overview:
Parametrised, pipelined, symmetric (linear-phase) FIR filter for signed fixed-point samples. It is the successor to the fixed 9-tap filter, adding:
- configurable tap count and widths
- run-time writable coefficients
- a sample-valid qualifier
- symmetric pre-addition, so only (TAPS+1)/2 multipliers are needed
- round-half-up output scaling with saturation
- a bypass mode

It sits between the noisy sample source and downstream signal processing on the single CLK domain.

Parameters:
DATA_W, 16, signed input sample width.
COEF_W, 16, signed coefficient width.
TAPS, 9, tap count; odd only, range 3..31. U=(TAPS+1)/2 unique coefficients; A=ceil(log2(U)).
OUT_W, 16, signed output width.
OUT_SHIFT, 14, right-shift applied to the accumulator (coefficient fractional bits); must be at least 1.

Ports:
CLK  in  1  clock; all logic on the rising edge.
RST  in  1  synchronous, active-high reset.
IN_VALID  in  1  NOISE_SIGNAL is valid this cycle.
NOISE_SIGNAL  in  DATA_W  signed input sample.
BYPASS  in  1  1: output is the centre-tap sample; 0: filtered output.
COEF_WE  in  1  coefficient write strobe.
COEF_ADDR  in  5  unique-coefficient index, 0..U-1.
COEF_DATA  in  COEF_W  signed coefficient value.
OUT_VALID  out  1  FILTERED_SIGNAL is valid this cycle.
FILTERED_SIGNAL  out  OUT_W  signed filtered sample.
OUT_SAT  out  1  FILTERED_SIGNAL was clamped; qualified by OUT_VALID.

Behaviour:
- One clock domain; reset is synchronous and active-high: RST sampled high at a CLK edge resets the block.
- Reset values:
  - delay line, all pipeline registers and the valid pipe: 0
  - OUT_VALID=0, FILTERED_SIGNAL=0, OUT_SAT=0
  - coefficients: coef[U-1]=1<<OUT_SHIFT (identity); all other coefficients 0
- Delay line x[0..TAPS-1]:
  - shifts only on edges where IN_VALID=1: x[0]<=NOISE_SIGNAL, x[i]<=x[i-1]
  - gaps in IN_VALID hold the line unchanged
- Coefficient mapping: h[i]=h[TAPS-1-i]=coef[i] for i<U-1; centre tap h[U-1]=coef[U-1].
- Pipeline stages, counted as edges after the accepting edge e:
  - e+1: pre-add p[i]=x[i]+x[TAPS-1-i] (DATA_W+1 bits); p[U-1]=x[U-1], sign-extended.
  - e+2: multiply m[i]=p[i]*coef[i] (DATA_W+COEF_W+1 bits, signed).
  - e+3..e+2+A: registered binary adder tree; each level grows 1 bit; an odd leftover operand is passed through a register.
  - e+3+A: round, shift, saturate into the output registers.
- Latency:
  - LAT=3+A edges from accept to OUT_VALID; 6 at the defaults.
  - The pipeline never stalls. OUT_VALID is the IN_VALID pipe delayed by LAT; exactly one OUT_VALID per accepted sample, in order.
- Rounding: r = (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, arithmetic shift (round half toward +inf).
- Saturation:
  - r > 2^(OUT_W-1)-1 -> clamp to max, OUT_SAT=1
  - r < -2^(OUT_W-1) -> clamp to min, OUT_SAT=1
  - otherwise OUT_SAT=0
- BYPASS:
  - sampled alongside the pre-add stage; selects x[U-1] for the output path, carried with identical latency
  - rounding is not applied; x[U-1] is saturated to OUT_W if OUT_W<DATA_W
  - OUT_SAT follows the same clamp rule
- Coefficient writes:
  - a write with COEF_WE=1 at edge w is used by the multiply at edge w+1 onward
  - in-flight samples may mix old and new coefficients; this is accepted
  - COEF_ADDR>=U: write ignored
  - writes are accepted regardless of IN_VALID
  - RST and COEF_WE in the same cycle: RST wins
- Reset mid-operation: all in-flight samples are discarded; OUT_VALID stays 0 until LAT edges after the first post-reset accepted sample.
- While OUT_VALID=0, FILTERED_SIGNAL and OUT_SAT hold their last values.

Test Plan:
1. Default coefficients after reset; feed impulse 0x1000 followed by zeros, IN_VALID=1 continuously -> first outputs 0x0000; the 0x1000 appears on the 5th output (index 4); OUT_VALID rises exactly 6 cycles after the first accept.
2. Write coef[0..4]=0x04F6,0x0A34,0x1089,0x1496,0x160F; impulse 0x4000 -> output sequence 0x04F6,0x0A34,0x1089,0x1496,0x160F,0x1496,0x1089,0x0A34,0x04F6, then 0; OUT_SAT=0 throughout.
3. Rounding: centre coef=0x2000, others 0. Input 0x0003 -> output 0x0002. Input 0xFFFD (-3) -> output 0xFFFF (-1).
4. Saturation: all coefs 0x7FFF. Constant input 0x7FFF -> output 0x7FFF with OUT_SAT=1. Constant input 0x8000 -> output 0x8000 with OUT_SAT=1.
5. IN_VALID toggling 1,0,1,0 with impulse 0x4000 (test-2 coefficients) -> same 9-value sequence, one output per accepted sample, OUT_VALID spaced to match the input gaps.
6. Assert RST for one cycle mid-stream with BYPASS=1 -> OUT_VALID=0 and FILTERED_SIGNAL=0 the next cycle; coefficients return to identity. The bypassed post-reset sample 0x1234 appears exactly LAT edges after the centre tap receives it.
